count_seq_checker: RTL and testbench

Receive-side monitor for the free-running binary up-counter bus. Samples a WIDTH-bit count each qualified cycle and checks that it advances by exactly +1 modulo 2^WIDTH. Acquires lock after a run of good steps, then reports wraps, counter restarts and sequence errors. Sits downstream of any counter block in the lab designs and drives status LEDs or a debug display.

---
 rtl/count_seq_checker.sv | 149 ++++++++++++++
 tb/tb_count_seq_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Receive-side monitor for a free-running up-counter bus: locks onto +1 steps, flags errors.
// Optional COUNT_SEQ_CHECKER_ERR_CLR_EN adds i_err_clr to zero the error counter.
module count_seq_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_a_valid,
`ifdef COUNT_SEQ_CHECKER_ERR_CLR_EN
  input  logic             i_err_clr,
`endif
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic             o_restart_pulse,
  output logic             o_wrap_pulse,
  output logic [ERR_W-1:0] o_err_count
);

  localparam int unsigned GoodW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int unsigned BadW  = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked, StLoss} state_e;

  state_e           r_state, w_state;
  logic [WIDTH-1:0] r_prev;
  logic [GoodW-1:0] r_good_run, w_good_run;
  logic [BadW-1:0]  r_bad_run, w_bad_run;
  logic             r_locked, r_err_pulse, r_restart_pulse, r_wrap_pulse;
  logic [ERR_W-1:0] r_err_count, w_err_count;

  logic             w_good, w_restart, w_prev_max;
  logic             w_err, w_rst_p, w_wrap;
  logic [31:0]      w_good_inc, w_bad_inc;

  // max->0 is a good step because the sum wraps at WIDTH bits
  assign w_good     = (i_a == r_prev + WIDTH'(1));
  assign w_restart  = (i_a == '0) && !w_good;
  assign w_prev_max = &r_prev;
  assign w_good_inc = 32'(r_good_run) + 32'd1;
  assign w_bad_inc  = 32'(r_bad_run) + 32'd1;

  always_comb begin
    w_state    = r_state;
    w_good_run = r_good_run;
    w_bad_run  = r_bad_run;
    w_err      = 1'b0;
    w_rst_p    = 1'b0;
    w_wrap     = 1'b0;
    if (i_a_valid) begin
      unique case (r_state)
        StIdle: begin
          w_state    = StAcquire;
          w_good_run = '0;
        end
        StAcquire: begin
          if (!w_good) begin
            w_good_run = '0;
          end else if (w_good_inc == LOCK_CNT) begin
            w_state    = StLocked;
            w_good_run = '0;
          end else begin
            w_good_run = w_good_inc[GoodW-1:0];
          end
        end
        StLocked: begin
          if (w_good) begin
            w_wrap = w_prev_max;
          end else if (w_restart) begin
            w_rst_p = 1'b1;
          end else begin
            w_err     = 1'b1;
            w_bad_run = BadW'(1);
            w_state   = (LOSS_CNT == 1) ? StAcquire : StLoss;
            if (LOSS_CNT == 1) begin
              w_bad_run  = '0;
              w_good_run = '0;
            end
          end
        end
        StLoss: begin
          if (w_good || w_restart) begin
            w_state   = StLocked;
            w_bad_run = '0;
            w_wrap    = w_good && w_prev_max;
            w_rst_p   = w_restart;
          end else begin
            w_err = 1'b1;
            if (w_bad_inc == LOSS_CNT) begin
              w_state    = StAcquire;
              w_bad_run  = '0;
              w_good_run = '0;
            end else begin
              w_bad_run = w_bad_inc[BadW-1:0];
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    w_err_count = r_err_count;
    if (w_err && !(&r_err_count)) begin
      w_err_count = r_err_count + ERR_W'(1);
    end
`ifdef COUNT_SEQ_CHECKER_ERR_CLR_EN
    if (i_err_clr) begin
      w_err_count = '0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state         <= StIdle;
      r_prev          <= '0;
      r_good_run      <= '0;
      r_bad_run       <= '0;
      r_locked        <= 1'b0;
      r_err_pulse     <= 1'b0;
      r_restart_pulse <= 1'b0;
      r_wrap_pulse    <= 1'b0;
      r_err_count     <= '0;
    end else begin
      r_state         <= w_state;
      r_good_run      <= w_good_run;
      r_bad_run       <= w_bad_run;
      r_locked        <= (w_state == StLocked) || (w_state == StLoss);
      r_err_pulse     <= w_err;
      r_restart_pulse <= w_rst_p;
      r_wrap_pulse    <= w_wrap;
      r_err_count     <= w_err_count;
      if (i_a_valid) begin
        r_prev <= i_a;
      end
    end
  end

  assign o_locked        = r_locked;
  assign o_err_pulse     = r_err_pulse;
  assign o_restart_pulse = r_restart_pulse;
  assign o_wrap_pulse    = r_wrap_pulse;
  assign o_err_count     = r_err_count;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: a behavioural model queues expected outputs per step.
module tb_count_seq_checker;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned LOSS_CNT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic             locked, err_p, rst_p, wrap_p;
  logic [7:0]       err_cnt;
  logic             locked2, err_p2, rst_p2, wrap_p2;
  logic [1:0]       err_cnt2;
`ifdef COUNT_SEQ_CHECKER_ERR_CLR_EN
  logic             err_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  count_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_a_valid(a_valid),
`ifdef COUNT_SEQ_CHECKER_ERR_CLR_EN
    .i_err_clr(err_clr),
`endif
    .o_locked(locked), .o_err_pulse(err_p), .o_restart_pulse(rst_p),
    .o_wrap_pulse(wrap_p), .o_err_count(err_cnt)
  );

  count_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_a_valid(a_valid),
`ifdef COUNT_SEQ_CHECKER_ERR_CLR_EN
    .i_err_clr(err_clr),
`endif
    .o_locked(locked2), .o_err_pulse(err_p2), .o_restart_pulse(rst_p2),
    .o_wrap_pulse(wrap_p2), .o_err_count(err_cnt2)
  );

  typedef struct {
    logic       locked;
    logic       err;
    logic       rst_p;
    logic       wrap;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: 0 idle, 1 acquire, 2 locked, 3 loss
  int m_state, m_prev, m_good, m_bad, m_cnt8, m_cnt2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_reset();
    exp_t e;
    m_state = 0; m_prev = 0; m_good = 0; m_bad = 0; m_cnt8 = 0; m_cnt2 = 0;
    e.locked = 0; e.err = 0; e.rst_p = 0; e.wrap = 0; e.cnt = 0; e.cnt2 = 0;
    return e;
  endfunction

  function automatic exp_t model_step(input int av, input bit v);
    exp_t e;
    bit   good, rs, err;
    e.err = 0; e.rst_p = 0; e.wrap = 0;
    err = 0;
    if (v) begin
      good = (av == ((m_prev + 1) % 16));
      rs   = (av == 0) && !good;
      case (m_state)
        0: begin m_state = 1; m_good = 0; end
        1: begin
          if (!good) m_good = 0;
          else if (m_good + 1 == LOCK_CNT) begin m_state = 2; m_good = 0; end
          else m_good++;
        end
        2: begin
          if (good) e.wrap = (m_prev == 15);
          else if (rs) e.rst_p = 1;
          else begin err = 1; m_bad = 1; m_state = 3; end
        end
        default: begin
          if (good) begin m_state = 2; m_bad = 0; e.wrap = (m_prev == 15); end
          else if (rs) begin m_state = 2; m_bad = 0; e.rst_p = 1; end
          else begin
            err = 1;
            if (m_bad + 1 == LOSS_CNT) begin m_state = 1; m_bad = 0; m_good = 0; end
            else m_bad++;
          end
        end
      endcase
      m_prev = av;
    end
    if (err) begin
      e.err = 1;
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    e.locked = (m_state >= 2);
    e.cnt    = 8'(m_cnt8);
    e.cnt2   = 2'(m_cnt2);
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    chk("locked", 32'(locked), 32'(e.locked));
    chk("err_pulse", 32'(err_p), 32'(e.err));
    chk("restart_pulse", 32'(rst_p), 32'(e.rst_p));
    chk("wrap_pulse", 32'(wrap_p), 32'(e.wrap));
    chk("err_count", 32'(err_cnt), 32'(e.cnt));
    chk("locked_w2", 32'(locked2), 32'(e.locked));
    chk("err_count_w2", 32'(err_cnt2), 32'(e.cnt2));
  endtask

  task automatic step(input int av, input bit v);
    @(negedge clk);
    rst     = 1'b1;
    a       = 4'(av);
    a_valid = v;
    q.push_back(model_step(av, v));
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst     = 1'b0;
      a       = 4'd9;
      a_valid = 1'b1;
      q.push_back(model_reset());
      @(posedge clk);
      #1;
      compare_out();
    end
  endtask

  initial begin
    int r, av;
    rst = 1'b0; a = '0; a_valid = 1'b0;
    do_reset(2);
    for (int i = 0; i <= 4; i++) step(i, 1);             // acquire and lock
    for (int i = 5; i <= 15; i++) step(i, 1);
    step(0, 1); step(1, 1);                                // wrap
    for (int i = 2; i <= 7; i++) step(i, 1);
    step(9, 1); step(10, 1); step(12, 1); step(14, 1);     // errors, lock loss
    step(15, 1); step(0, 1); step(1, 1); step(2, 1);       // relock
    for (int i = 3; i <= 9; i++) step(i, 1);
    step(0, 1); step(1, 1);                                // restart
    step(2, 1); step(3, 1);
    for (int i = 0; i < 5; i++) step(11, 0);               // gap
    step(4, 1);
    step(6, 1); step(7, 1); step(9, 1); step(10, 1);       // saturate narrow counter
    step(12, 1); step(13, 1); step(15, 1); step(0, 1);
    step(1, 1); step(1, 1); step(1, 1);                    // stuck value drops lock
    for (int i = 0; i < 80; i++) begin
      r  = int'($urandom_range(0, 9));
      av = (r < 7) ? (m_prev + 1) % 16 : (r == 7) ? 0 : int'($urandom_range(0, 15));
      step(av, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 8; i++) step((m_prev + 1) % 16, 1);
    do_reset(1);                                           // reset mid-run drops lock
    step(5, 1); step(6, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
